alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 8-bit ALU between two requesters, e.g. the main execute path (port 0) and an auxiliary address/branch unit (port 1). Each operation is accepted with a valid/ready handshake and its operands are latched. The latched values drive the ALU for exactly one cycle, and the result/shift-carry is returned on a per-requester response channel with backpressure. Only one operation is in flight at any time.

Parameters:
W, 8, operand/result width (matches ALU datapath)
CMDW, 4, ALU command width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
reqN_valid  in  1  requester N (N=0,1) has an operation
reqN_ready  out  1  arbiter accepts requester N's operation this cycle
reqN_cmd  in  CMDW  ALU command for requester N
reqN_a  in  W  operand A for requester N
reqN_b  in  W  operand B for requester N
reqN_sc  in  1  shift/carry-in for requester N
rspN_valid  out  1  result for requester N is available
rspN_ready  in  1  requester N consumes the result
rspN_rslt  out  W  result for requester N
rspN_sc  out  1  shift/carry-out for requester N
alu_cmd  out  CMDW  to ALU command input
alu_inA  out  W  to ALU operand A
alu_inB  out  W  to ALU operand B
alu_sc_i  out  1  to ALU shift/carry-in
alu_rslt  in  W  from ALU result
alu_sc_o  in  1  from ALU shift/carry-out
busy  out  1  operation in flight (EXEC or RESP)
last_grant  out  1  ID of most recently granted requester

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- State machine: IDLE -> EXEC -> RESP -> IDLE. The encoding is free.
- Reset values:
  - State = IDLE; rr pointer = 0 (port 0 has priority).
  - Operand, command and sc latches = 0, so alu_* = 0.
  - Response registers = 0; rspN_valid = 0.
  - last_grant = 0; busy = 0.
- IDLE:
  - reqN_ready is combinational and asserted for at most one N, and only in IDLE.
  - Grant rule: if exactly one reqN_valid is high, grant that requester. If both are high, grant the requester the rr pointer selects.
  - On the grant edge: latch cmd/a/b/sc and the granted ID; set last_grant to that ID; set the pointer to the other requester; go to EXEC.
  - If no request is valid: remain in IDLE and keep the latches unchanged.
- EXEC (1 cycle):
  - alu_* are driven from the latches. They are always driven from the latches in every state, never combinationally from the request inputs.
  - At the end of the cycle, capture alu_rslt and alu_sc_o into the granted port's response registers; go to RESP.
- RESP:
  - The granted port's rspN_valid = 1; the other port's rspN_valid = 0.
  - rspN_rslt/rspN_sc hold stable until rspN_ready = 1.
  - When rspN_valid and rspN_ready are both high: clear valid at the edge and go to IDLE.
- Latency and throughput:
  - Grant at cycle t, rsp_valid at t+2. With rsp_ready held high, rsp completes at t+2 and the next grant is at t+3.
  - Minimum 3 cycles per operation.
- The command is opaque: all 16 codes pass through unmodified. The arbiter never inspects cmd, and no width conversion is performed.
- Requester obligations:
  - Hold valid and all fields stable until ready.
  - Withdrawing valid before grant is permitted; nothing is latched.
- A request arriving while busy waits; it is considered only when the FSM returns to IDLE.
- A requester may present a new request while its own response is pending. It is granted only after that response completes.
- rspN_ready while rspN_valid = 0: ignored.
- Reset asserted in any state, including mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is emitted, and all registers return to their reset values on that edge.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.

Test Plan:
1. After reset, req0 only with cmd=0000, a=5, b=3 -> req0_ready pulses at t, alu_cmd=0000/inA=5/inB=3 at t+1, rsp0_valid=1 with rsp0_rslt=8 at t+2; rsp1_valid stays 0.
2. Both valid right after reset, req0 = sub 10-4 and req1 = xor 0xF0^0x3C -> req0 is granted first (rsp0_rslt=6, last_grant=0), then req1 (rsp1_rslt=0xCC, last_grant=1). The grants are exactly 3 cycles apart.
3. Hold rsp1_ready=0 for 4 cycles after rsp1_valid rises (and, 0xAA&0x0F) -> rsp1_rslt=0x0A stays stable, busy=1, a pending req0 is not granted until the cycle after rsp1_ready=1.
4. Both requesters continuously valid for 6 operations -> grant order 0,1,0,1,0,1 and no ready pulse outside IDLE.
5. reset=1 in the EXEC cycle of req0 (add 200+100) -> next cycle: IDLE, busy=0, rsp0_valid never asserts, alu_* = 0; a subsequent req1 is granted immediately.
6. req0 with cmd=1011, sc=1 and ALU model sc_o=1 -> alu_sc_i=1 during EXEC, rsp0_sc=1 in RESP; a following op with sc_o=0 -> rsp0_sc=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Operands are latched at grant; the ALU runs one cycle and then the result is returned.
module alu_arbiter #(
  parameter int W    = 8,
  parameter int CMDW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [CMDW-1:0] req0_cmd,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req0_sc,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [CMDW-1:0] req1_cmd,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic            req1_sc,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [W-1:0]    rsp0_rslt,
  output logic            rsp0_sc,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [W-1:0]    rsp1_rslt,
  output logic            rsp1_sc,
  output logic [CMDW-1:0] alu_cmd,
  output logic [W-1:0]    alu_inA,
  output logic [W-1:0]    alu_inB,
  output logic            alu_sc_i,
  input  logic [W-1:0]    alu_rslt,
  input  logic            alu_sc_o,
  output logic            busy,
  output logic            last_grant
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            gid_q, gid_d;
  logic            last_q, last_d;
  logic [CMDW-1:0] cmd_q, cmd_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sc_q, sc_d;
  logic [W-1:0]    rslt0_q, rslt0_d;
  logic [W-1:0]    rslt1_q, rslt1_d;
  logic            sco0_q, sco0_d;
  logic            sco1_q, sco1_d;
  logic            rv0_q, rv0_d;
  logic            rv1_q, rv1_d;
  logic            g0, g1;

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    sc_d    = sc_q;
    rslt0_d = rslt0_q;
    rslt1_d = rslt1_q;
    sco0_d  = sco0_q;
    sco1_d  = sco1_q;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
    unique case (state_q)
      IDLE: begin
        // rr_q picks the winner only under contention
        g0 = req0_valid && (!req1_valid || !rr_q);
        g1 = req1_valid && (!req0_valid || rr_q);
        if (g0 || g1) begin
          gid_d   = g1;
          last_d  = g1;
          rr_d    = ~g1;
          cmd_d   = g1 ? req1_cmd : req0_cmd;
          a_d     = g1 ? req1_a : req0_a;
          b_d     = g1 ? req1_b : req0_b;
          sc_d    = g1 ? req1_sc : req0_sc;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (gid_q) begin
          rslt1_d = alu_rslt;
          sco1_d  = alu_sc_o;
          rv1_d   = 1'b1;
        end else begin
          rslt0_d = alu_rslt;
          sco0_d  = alu_sc_o;
          rv0_d   = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if ((rv0_q && rsp0_ready) || (rv1_q && rsp1_ready)) begin
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b0;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sc_q    <= 1'b0;
      rslt0_q <= '0;
      rslt1_q <= '0;
      sco0_q  <= 1'b0;
      sco1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sc_q    <= sc_d;
      rslt0_q <= rslt0_d;
      rslt1_q <= rslt1_d;
      sco0_q  <= sco0_d;
      sco1_q  <= sco1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rsp0_valid = rv0_q;
  assign rsp1_valid = rv1_q;
  assign rsp0_rslt  = rslt0_q;
  assign rsp1_rslt  = rslt1_q;
  assign rsp0_sc    = sco0_q;
  assign rsp1_sc    = sco1_q;
  assign alu_cmd    = cmd_q;
  assign alu_inA    = a_q;
  assign alu_inB    = b_q;
  assign alu_sc_i   = sc_q;
  assign busy       = (state_q != IDLE);
  assign last_grant = last_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model.
// Inputs change 1ns after the rising edge and outputs are sampled there.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_sc;
  logic [3:0] req0_cmd;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sc;
  logic [3:0] req1_cmd;
  logic [7:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp0_sc;
  logic [7:0] rsp0_rslt;
  logic       rsp1_valid, rsp1_ready, rsp1_sc;
  logic [7:0] rsp1_rslt;
  logic [3:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB, alu_rslt;
  logic       alu_sc_i, alu_sc_o, busy, last_grant;
  logic       tb_sc_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(8), .CMDW(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sc(req0_sc),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sc(req1_sc),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_rslt(rsp0_rslt), .rsp0_sc(rsp0_sc),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_rslt(rsp1_rslt), .rsp1_sc(rsp1_sc),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt),
    .alu_sc_o(alu_sc_o), .busy(busy), .last_grant(last_grant)
  );

  always_comb begin
    alu_rslt = alu_inA;
    unique case (alu_cmd)
      4'h0: alu_rslt = alu_inA + alu_inB;
      4'h1: alu_rslt = alu_inA - alu_inB;
      4'h2: alu_rslt = alu_inA & alu_inB;
      4'h3: alu_rslt = alu_inA | alu_inB;
      4'h4: alu_rslt = alu_inA ^ alu_inB;
      default: alu_rslt = alu_inA;
    endcase
  end
  assign alu_sc_o = tb_sc_o;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 0; req0_cmd = 0; req0_a = 0; req0_b = 0; req0_sc = 0;
    req1_valid = 0; req1_cmd = 0; req1_a = 0; req1_b = 0; req1_sc = 0;
    rsp0_ready = 0; rsp1_ready = 0; tb_sc_o = 0;
    do_reset();
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    nvec++;
    if (last_grant !== 1'b0) begin
      nerr++; $display("FAIL reset_last got=%b exp=0", last_grant);
    end
    nvec++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      nerr++; $display("FAIL reset_rspv got=%b exp=00", {rsp0_valid, rsp1_valid});
    end
    nvec++;
    if ({alu_cmd, alu_inA, alu_inB, alu_sc_i} !== 21'd0) begin
      nerr++; $display("FAIL reset_alu got=%h exp=0", {alu_cmd, alu_inA, alu_inB, alu_sc_i});
    end
    nvec++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      nerr++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_single();
    req0_valid = 1; req0_cmd = 4'h0; req0_a = 8'd5; req0_b = 8'd3;
    #1;
    nvec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    #1;
    nvec++;
    if ({alu_cmd, alu_inA, alu_inB} !== {4'h0, 8'd5, 8'd3}) begin
      nerr++; $display("FAIL single_alu got=%h exp=%h", {alu_cmd, alu_inA, alu_inB}, {4'h0, 8'd5, 8'd3});
    end
    nvec++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL single_busy got=%b exp=1", busy);
    end
    step();
    nvec++;
    if ({rsp0_valid, rsp1_valid, rsp0_rslt} !== {2'b10, 8'd8}) begin
      nerr++; $display("FAIL single_rsp got=%b%b %0d exp=10 8", rsp0_valid, rsp1_valid, rsp0_rslt);
    end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    nvec++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      nerr++; $display("FAIL single_done got=%b exp=00", {rsp0_valid, busy});
    end
  endtask

  task automatic test_both();
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_cmd = 4'h1; req0_a = 8'd10; req0_b = 8'd4;
    req1_valid = 1; req1_cmd = 4'h4; req1_a = 8'hF0; req1_b = 8'h3C;
    #1;
    nvec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++; $display("FAIL both_g0 got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    #1;
    nvec++;
    if ({last_grant, req1_ready} !== 2'b00) begin
      nerr++; $display("FAIL both_exec0 got=%b exp=00", {last_grant, req1_ready});
    end
    step();
    nvec++;
    if ({rsp0_valid, rsp0_rslt, req1_ready} !== {1'b1, 8'd6, 1'b0}) begin
      nerr++; $display("FAIL both_rsp0 got=%b %0d %b exp=1 6 0", rsp0_valid, rsp0_rslt, req1_ready);
    end
    step();
    nvec++;
    if (req1_ready !== 1'b1) begin
      nerr++; $display("FAIL both_g1 got=%b exp=1", req1_ready);
    end
    step();
    req1_valid = 0;
    #1;
    nvec++;
    if (last_grant !== 1'b1) begin
      nerr++; $display("FAIL both_last1 got=%b exp=1", last_grant);
    end
    step();
    nvec++;
    if ({rsp1_valid, rsp0_valid, rsp1_rslt} !== {2'b10, 8'hCC}) begin
      nerr++; $display("FAIL both_rsp1 got=%b%b %h exp=10 cc", rsp1_valid, rsp0_valid, rsp1_rslt);
    end
    step();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_backpressure();
    req1_valid = 1; req1_cmd = 4'h2; req1_a = 8'hAA; req1_b = 8'h0F;
    #1;
    nvec++;
    if (req1_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_g1 got=%b exp=1", req1_ready);
    end
    step();
    req1_valid = 0;
    req0_valid = 1; req0_cmd = 4'h0; req0_a = 8'd1; req0_b = 8'd1;
    rsp0_ready = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if ({rsp1_valid, rsp1_rslt, busy, req0_ready} !== {1'b1, 8'h0A, 2'b10}) begin
        nerr++; $display("FAIL bp_hold%0d got=%b %h %b %b exp=1 0a 1 0", i, rsp1_valid, rsp1_rslt, busy, req0_ready);
      end
      step();
    end
    rsp1_ready = 1;
    #1;
    nvec++;
    if (req0_ready !== 1'b0) begin
      nerr++; $display("FAIL bp_rel_ready got=%b exp=0", req0_ready);
    end
    step();
    rsp1_ready = 0;
    #1;
    nvec++;
    if ({rsp1_valid, req0_ready} !== 2'b01) begin
      nerr++; $display("FAIL bp_g0 got=%b exp=01", {rsp1_valid, req0_ready});
    end
    step();
    req0_valid = 0;
    step();
    nvec++;
    if ({rsp0_valid, rsp0_rslt} !== {1'b1, 8'd2}) begin
      nerr++; $display("FAIL bp_rsp0 got=%b %0d exp=1 2", rsp0_valid, rsp0_rslt);
    end
    step();
    rsp0_ready = 0;
  endtask

  task automatic test_fairness();
    logic exp_id;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_cmd = 4'h3; req0_a = 8'h01; req0_b = 8'h10;
    req1_valid = 1; req1_cmd = 4'h3; req1_a = 8'h02; req1_b = 8'h20;
    for (int i = 0; i < 6; i++) begin
      exp_id = (i % 2 == 1);
      #1;
      nvec++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        nerr++; $display("FAIL fair_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      step();
      nvec++;
      if ({last_grant, req0_ready, req1_ready} !== {exp_id, 2'b00}) begin
        nerr++; $display("FAIL fair_exec%0d got=%b exp=%b00", i, {last_grant, req0_ready, req1_ready}, exp_id);
      end
      step();
      nvec++;
      if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== {~exp_id, exp_id, 2'b00}) begin
        nerr++; $display("FAIL fair_rsp%0d got=%b exp=%b%b00", i, {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, ~exp_id, exp_id);
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_reset_exec();
    req0_valid = 1; req0_cmd = 4'h0; req0_a = 8'd200; req0_b = 8'd100;
    #1;
    nvec++;
    if (req0_ready !== 1'b1) begin
      nerr++; $display("FAIL rx_g0 got=%b exp=1", req0_ready);
    end
    step();
    req0_valid = 0;
    reset = 1;
    #1;
    nvec++;
    if (alu_inA !== 8'd200) begin
      nerr++; $display("FAIL rx_exec_a got=%0d exp=200", alu_inA);
    end
    step();
    reset = 0;
    #1;
    nvec++;
    if ({busy, rsp0_valid, last_grant, alu_cmd, alu_inA, alu_inB} !== 23'd0) begin
      nerr++; $display("FAIL rx_cleared got=%b%b%b %h %h %h exp=0", busy, rsp0_valid, last_grant, alu_cmd, alu_inA, alu_inB);
    end
    req1_valid = 1; req1_cmd = 4'h0; req1_a = 8'd1; req1_b = 8'd2;
    #1;
    nvec++;
    if (req1_ready !== 1'b1) begin
      nerr++; $display("FAIL rx_g1 got=%b exp=1", req1_ready);
    end
    step();
    req1_valid = 0;
    step();
    nvec++;
    if ({rsp0_valid, rsp1_valid, rsp1_rslt} !== {2'b01, 8'd3}) begin
      nerr++; $display("FAIL rx_rsp1 got=%b%b %0d exp=01 3", rsp0_valid, rsp1_valid, rsp1_rslt);
    end
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
  endtask

  task automatic test_sc();
    req0_valid = 1; req0_cmd = 4'hB; req0_a = 8'h12; req0_b = 8'h34;
    req0_sc = 1; tb_sc_o = 1;
    #1;
    nvec++;
    if (req0_ready !== 1'b1) begin
      nerr++; $display("FAIL sc_g0 got=%b exp=1", req0_ready);
    end
    step();
    req0_valid = 0;
    #1;
    nvec++;
    if ({alu_cmd, alu_sc_i} !== {4'hB, 1'b1}) begin
      nerr++; $display("FAIL sc_exec1 got=%h %b exp=b 1", alu_cmd, alu_sc_i);
    end
    step();
    nvec++;
    if ({rsp0_valid, rsp0_sc, rsp0_rslt} !== {2'b11, 8'h12}) begin
      nerr++; $display("FAIL sc_rsp1 got=%b%b %h exp=11 12", rsp0_valid, rsp0_sc, rsp0_rslt);
    end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    req0_valid = 1; req0_cmd = 4'hF; req0_a = 8'h77; req0_sc = 0;
    tb_sc_o = 0;
    step();
    req0_valid = 0;
    #1;
    nvec++;
    if ({alu_cmd, alu_sc_i} !== {4'hF, 1'b0}) begin
      nerr++; $display("FAIL sc_exec0 got=%h %b exp=f 0", alu_cmd, alu_sc_i);
    end
    step();
    nvec++;
    if ({rsp0_valid, rsp0_sc, rsp0_rslt} !== {2'b10, 8'h77}) begin
      nerr++; $display("FAIL sc_rsp0 got=%b%b %h exp=10 77", rsp0_valid, rsp0_sc, rsp0_rslt);
    end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_both();
    test_backpressure();
    test_fairness();
    test_reset_exec();
    test_sc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
